// File: rtl/cpu_bus_responder.sv
// Slave side of the 65C02 bus: RAM, ROM with RDY wait states, and a 16-byte IO page
// holding the RGB LED register and a 16-bit tick timer with a compare interrupt.
module cpu_bus_responder #(
    parameter int          RAM_AW   = 12,
    parameter int          ROM_AW   = 12,
    parameter string       ROM_FILE = "",
    parameter int          ROM_WAIT = 1,
    parameter logic [15:0] IO_BASE  = 16'hD000,
    parameter logic [7:0]  UNMAPPED = 8'hEA
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        IRQ,
    output logic [2:0]  led
);

    localparam int         RAM_SIZE  = 1 << RAM_AW;
    localparam int         ROM_SIZE  = 1 << ROM_AW;
    localparam logic [2:0] WAIT_LOAD = (ROM_WAIT > 1) ? 3'(ROM_WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} wait_state_t;

    wait_state_t state, state_next;
    logic [2:0]  cnt, cnt_next;

    logic [7:0]  ram [RAM_SIZE];
    logic [7:0]  rom [ROM_SIZE];

    logic        io_sel, rom_sel, ram_sel;
    logic [3:0]  offset;
    logic        bus_wr, io_wr, io_rd, rom_read;
    logic [7:0]  rd_data;

    logic [2:0]  led_reg;
    logic [15:0] tick, tick_inc, cmp;
    logic [7:0]  hold;
    logic        match, ctrl_run, ctrl_irq;
    logic        tick_clr, match_set, match_clr;

    // Unloaded ROM bytes read as NOP so a partial image still runs safely.
    initial begin
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'hEA;
    end

    assign io_sel   = (AB[15:4] == IO_BASE[15:4]);
    assign rom_sel  = !io_sel && (AB[15:ROM_AW] == '1);
    assign ram_sel  = !io_sel && !rom_sel && (AB[15:RAM_AW] == '0);
    assign offset   = AB[3:0];
    assign rom_read = rom_sel && !WE;
    assign bus_wr   = WE && RDY;
    assign io_wr    = bus_wr && io_sel;
    assign io_rd    = !WE && RDY && io_sel;

    always_comb begin
        rd_data = UNMAPPED;
        if (io_sel) begin
            case (offset)
                4'd0:    rd_data = {5'b0, led_reg};
                4'd1:    rd_data = tick[7:0];
                4'd2:    rd_data = hold;
                4'd3:    rd_data = {7'b0, match};
                4'd4:    rd_data = cmp[7:0];
                4'd5:    rd_data = cmp[15:8];
                4'd6:    rd_data = {ctrl_irq, 6'b0, ctrl_run};
                default: rd_data = 8'h00;
            endcase
        end else if (rom_sel) begin
            rd_data = rom[AB[ROM_AW-1:0]];
        end else if (ram_sel) begin
            rd_data = ram[AB[RAM_AW-1:0]];
        end
    end

    // The IDLE stall cycle counts as the first wait, so WAIT covers the remaining ROM_WAIT-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        RDY        = 1'b1;
        case (state)
            ST_IDLE: begin
                if (reset_n && rom_read && (ROM_WAIT > 0)) begin
                    RDY        = 1'b0;
                    cnt_next   = WAIT_LOAD;
                    state_next = (WAIT_LOAD == 3'd0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                RDY      = 1'b0;
                cnt_next = cnt - 3'd1;
                if (cnt <= 3'd1) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            DI    <= 8'h00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            DI    <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (bus_wr && ram_sel) ram[AB[RAM_AW-1:0]] <= DO;
    end

    assign tick_inc  = tick + 16'd1;
    assign tick_clr  = io_wr && (offset == 4'd1 || offset == 4'd2);
    assign match_set = ctrl_run && !tick_clr && (tick_inc == cmp);
    assign match_clr = io_wr && (offset == 4'd3) && DO[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_reg  <= 3'b000;
            tick     <= 16'h0000;
            hold     <= 8'h00;
            match    <= 1'b0;
            cmp      <= 16'hFFFF;
            ctrl_run <= 1'b0;
            ctrl_irq <= 1'b0;
            IRQ      <= 1'b0;
        end else begin
            if (io_wr && offset == 4'd0) led_reg <= DO[2:0];
            if (io_wr && offset == 4'd4) cmp[7:0] <= DO;
            if (io_wr && offset == 4'd5) cmp[15:8] <= DO;
            if (io_wr && offset == 4'd6) begin
                ctrl_run <= DO[0];
                ctrl_irq <= DO[7];
            end
            if (tick_clr) tick <= 16'h0000;
            else if (ctrl_run) tick <= tick_inc;
            // Latching the high byte on a TICK_LO read gives software a coherent 16-bit sample.
            if (io_rd && offset == 4'd1) hold <= tick[15:8];
            if (match_set) match <= 1'b1;
            else if (match_clr) match <= 1'b0;
            IRQ <= match && ctrl_irq;
        end
    end

    assign led = led_reg;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: one instance with two ROM wait states and a
// second with none, both driven by the same emulated CPU bus.
module tb_cpu_bus_responder;

    localparam int         WAITS   = 2;
    localparam logic [7:0] ROM_BYTE = 8'hEA;

    typedef struct {
        string      tag;
        logic [7:0] exp;
        int         due;
    } sbEntry_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI, DI0;
    logic        RDY, RDY0;
    logic        IRQ, IRQ0;
    logic [2:0]  led, led0;

    sbEntry_t    sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          nwLow = 0;
    logic        rdySeen, irqSeen;

    cpu_bus_responder #(.ROM_WAIT(WAITS)) dut (
        .clk(clk), .reset_n(reset_n), .AB(AB), .DO(DO), .WE(WE),
        .DI(DI), .RDY(RDY), .IRQ(IRQ), .led(led)
    );

    cpu_bus_responder #(.ROM_WAIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .AB(AB), .DO(DO), .WE(WE),
        .DI(DI0), .RDY(RDY0), .IRQ(IRQ0), .led(led0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: inputs driven after the edge, outputs sampled mid-cycle, due reads scored.
    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] data);
        sbEntry_t e;
        AB = addr;
        WE = we;
        DO = data;
        @(negedge clk);
        rdySeen = RDY;
        irqSeen = IRQ;
        if (!RDY0) nwLow++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checkOutput(e.tag, {8'h00, DI}, {8'h00, e.exp});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic readExpect(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        sbEntry_t e;
        e.tag = tag;
        e.exp = exp;
        e.due = cyc + 1;
        sbq.push_back(e);
        applyStimulus(addr, 1'b0, 8'h00);
    endtask

    // Holds the address while RDY is low, as the CPU would.
    task automatic romRead(input logic [15:0] addr, input string tag);
        sbEntry_t e;
        int lows = 0;
        e.tag = tag;
        e.exp = ROM_BYTE;
        e.due = cyc + WAITS;
        sbq.push_back(e);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(addr, 1'b0, 8'h00);
            if (rdySeen) break;
            lows++;
        end
        checkOutput({tag, "_waits"}, 16'(lows), 16'(WAITS));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        AB = 16'h0000;
        DO = 8'h00;
        WE = 1'b0;
        #12;
        checkOutput("rst_di", {8'h00, DI}, 16'h0000);
        checkOutput("rst_rdy", {15'h0, RDY}, 16'h0001);
        checkOutput("rst_irq", {15'h0, IRQ}, 16'h0000);
        checkOutput("rst_led", {13'h0, led}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(16'h0123, 1'b1, 8'h5A);
        readExpect(16'h0123, 8'h5A, "ram_rd");
        readExpect(16'h1123, 8'hEA, "unmapped_rd");
        applyStimulus(16'h0FFF, 1'b1, 8'h3C);
        readExpect(16'h0FFF, 8'h3C, "ram_top");
        applyStimulus(16'h1123, 1'b1, 8'h99);
        readExpect(16'h0123, 8'h5A, "ram_noalias");
        readExpect(16'hD007, 8'h00, "io_reserved");

        romRead(16'hFFFC, "rom_fffc");
        romRead(16'hFFFD, "rom_fffd");
        romRead(16'hFFFE, "rom_fffe");

        applyStimulus(16'hD000, 1'b1, 8'hFF);
        checkOutput("led_wr", {13'h0, led}, 16'h0007);
        readExpect(16'hD000, 8'h07, "led_rd");
        applyStimulus(16'hF000, 1'b0, 8'h00);
        applyStimulus(16'hD000, 1'b1, 8'h00);
        checkOutput("stall_rdy", {15'h0, rdySeen}, 16'h0000);
        checkOutput("led_stall_wr", {13'h0, led}, 16'h0007);
        applyStimulus(16'hD007, 1'b0, 8'h00);
        applyStimulus(16'hD000, 1'b1, 8'h02);
        checkOutput("led_wr2", {13'h0, led}, 16'h0002);

        applyStimulus(16'hD004, 1'b1, 8'h05);
        applyStimulus(16'hD005, 1'b1, 8'h00);
        applyStimulus(16'hD006, 1'b1, 8'h81);
        repeat (5) applyStimulus(16'hD007, 1'b0, 8'h00);
        readExpect(16'hD003, 8'h01, "status_match");
        checkOutput("irq_latency", {15'h0, irqSeen}, 16'h0000);
        readExpect(16'hD001, 8'h06, "tick_lo");
        checkOutput("irq_set", {15'h0, irqSeen}, 16'h0001);
        applyStimulus(16'hD003, 1'b1, 8'h01);
        applyStimulus(16'hD007, 1'b0, 8'h00);
        applyStimulus(16'hD007, 1'b0, 8'h00);
        checkOutput("irq_cleared", {15'h0, irqSeen}, 16'h0000);

        // Tick is 10 here; the next match at 5 needs a full wrap through FFFF.
        AB = 16'hD007;
        WE = 1'b0;
        for (n = 1; n <= 70000; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (IRQ) break;
        end
        checkOutput("wrap_irq_edges", 16'(n), 16'(65532));

        applyStimulus(16'hD003, 1'b1, 8'h01);
        applyStimulus(16'hD001, 1'b1, 8'h00);
        AB = 16'hD007;
        WE = 1'b0;
        repeat (511) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        readExpect(16'hD001, 8'hFF, "coh_lo");
        readExpect(16'hD002, 8'h01, "coh_hi");
        readExpect(16'hD001, 8'h01, "coh_lo_next");
        applyStimulus(16'hD007, 1'b0, 8'h00);

        applyStimulus(16'hF000, 1'b0, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_rdy", {15'h0, RDY}, 16'h0001);
        checkOutput("midrst_di", {8'h00, DI}, 16'h0000);
        checkOutput("midrst_irq", {15'h0, IRQ}, 16'h0000);
        checkOutput("midrst_led", {13'h0, led}, 16'h0000);
        @(posedge clk);
        #2;
        AB = 16'hD007;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc += 2;
        romRead(16'hFFFC, "rom_after_rst");
        applyStimulus(16'hD007, 1'b0, 8'h00);

        checkOutput("nowait_rdy_low", 16'(nwLow), 16'h0000);
        checkOutput("sb_drain", 16'(sbq.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
